// File: rtl/if_id_imm_stage.sv
// LEGv8 IF/ID register with immediate-format classification and field extraction.
// Optional stall performance counter enabled by IF_ID_STALL_PERF_EN.
module if_id_imm_stage #(
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      imm_fmt,
  output logic [25:0]     imm_field,
  output logic            sign_bit,
  output logic [15:0]     stall_cnt
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_D    = 3'd2;
  localparam logic [2:0] FMT_CB   = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;

  logic            w_is_b;
  logic            w_is_cb;
  logic            w_is_d;
  logic            w_is_i;
  logic [2:0]      w_fmt;
  logic [25:0]     w_field;
  logic            w_sign;

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc;
  logic [2:0]      r_fmt;
  logic [25:0]     r_field;
  logic            r_sign;

  assign w_is_b  = in_instr[31:26] == 6'b000101;
  assign w_is_cb = (in_instr[31:24] == 8'b10110100) ||
                   (in_instr[31:24] == 8'b10110101) ||
                   (in_instr[31:24] == 8'b01010100);
  assign w_is_d  = (in_instr[31:21] == 11'b11111000010) ||
                   (in_instr[31:21] == 11'b11111000000);
  assign w_is_i  = (in_instr[31:22] == 10'b1001000100) ||
                   (in_instr[31:22] == 10'b1101000100);

  // Opcode groups are disjoint, so a one-hot decode keeps first-match order.
  always_comb begin
    w_fmt   = FMT_NONE;
    w_field = '0;
    w_sign  = 1'b0;
    unique case (1'b1)
      w_is_b: begin
        w_fmt   = FMT_B;
        w_field = in_instr[25:0];
        w_sign  = in_instr[25];
      end
      w_is_cb: begin
        w_fmt   = FMT_CB;
        w_field = {7'd0, in_instr[23:5]};
        w_sign  = in_instr[23];
      end
      w_is_d: begin
        w_fmt   = FMT_D;
        w_field = {17'd0, in_instr[20:12]};
        w_sign  = in_instr[20];
      end
      w_is_i: begin
        w_fmt   = FMT_I;
        w_field = {14'd0, in_instr[21:10]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_fmt   <= FMT_NONE;
      r_field <= '0;
      r_sign  <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_fmt   <= FMT_NONE;
      r_field <= '0;
      r_sign  <= 1'b0;
    end else if (!stall) begin
      r_valid <= 1'b1;
      r_instr <= in_instr;
      r_pc    <= in_pc;
      r_fmt   <= w_fmt;
      r_field <= w_field;
      r_sign  <= w_sign;
    end
  end

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_pc    = r_pc;
  assign imm_fmt   = r_fmt;
  assign imm_field = r_field;
  assign sign_bit  = r_sign;

`ifdef IF_ID_STALL_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (stall && !flush && r_valid &&
                 (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
